// File: rtl/riscv_mc_controller_if.sv
// Decode inputs and datapath control outputs between the multicycle RISC-V
// controller (slave) and the datapath that feeds it the IR fields (master).
interface riscv_mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;

    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       Illegal;

    modport master (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
        input  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Illegal
    );

    modport slave (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
        output ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, Illegal
    );
endinterface

// File: rtl/riscv_mc_controller.sv
// Moore-style sequencer for a multicycle RV32 subset (lw/sw/R/I-ALU/beq/jal);
// per-state controls are registered alongside the state.
//
// state    | meaning
// FETCH    | read instruction, IR <= mem[PC], PC <= PC+4
// DECODE   | read registers, precompute branch target
// MEMADR   | compute load/store address
// MEMREAD  | read data memory
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 to data memory
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALU result to rd
// BEQ      | compare, branch if equal
// JAL      | link PC+4, jump to target
// TRAP     | illegal instruction, held until reset
module riscv_mc_controller (
    input  logic                        clk,
    input  logic                        reset,
    riscv_mc_controller_if.slave        bus
);
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
    } state_t;

    typedef struct packed {
        logic       pcupdate;
        logic       branch;
        logic       irwrite;
        logic       regwrite;
        logic       memwrite;
        logic       adrsrc;
        logic       illegal;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic [1:0] resultsrc;
        logic [1:0] immsrc;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_FETCH = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                     2'b00, 2'b10, 2'b10, 2'b00, 2'b00};

    state_t state;
    state_t state_next;
    ctrl_t  ctrl_q;
    logic   funct_ok;

    assign funct_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b110) ||
                      (bus.funct3 == 3'b111);

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:    state_next = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = funct_ok ? EXECR : TRAP;
                    OP_I:         state_next = funct_ok ? EXECI : TRAP;
                    OP_BEQ:       state_next = (bus.funct3 == 3'b000) ? BEQ : TRAP;
                    OP_JAL:       state_next = JAL;
                    default:      state_next = TRAP;
                endcase
            end
            MEMADR:   state_next = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_next = MEMWB;
            EXECR, EXECI, JAL: state_next = ALUWB;
            MEMWB, MEMWRITE, ALUWB, BEQ: state_next = FETCH;
            TRAP:     state_next = TRAP;
            default:  state_next = FETCH;
        endcase
    end

    function automatic ctrl_t ctrl_for(input state_t s, input logic [6:0] opc);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:    c = CTRL_FETCH;
            DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; c.immsrc = 2'b10; end
            MEMADR: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
                c.immsrc  = (opc == OP_SW) ? 2'b01 : 2'b00;
            end
            MEMREAD:  c.adrsrc = 1'b1;
            MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
            MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
            EXECR:    begin c.alusrca = 2'b10; c.aluop = 2'b10; end
            EXECI:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10; end
            ALUWB:    c.regwrite = 1'b1;
            BEQ:      begin c.alusrca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; end
            JAL: begin
                c.alusrca  = 2'b01;
                c.alusrcb  = 2'b10;
                c.pcupdate = 1'b1;
                c.immsrc   = 2'b11;
            end
            TRAP:     c.illegal = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FETCH;
            ctrl_q <= CTRL_FETCH;
        end else begin
            state  <= state_next;
            ctrl_q <= ctrl_for(state_next, bus.op);
        end
    end

    // SUB for funct3=000 applies only to R-type; I-ALU ignores IR[30] there
    always_comb begin
        bus.ALUControl = 3'b000;
        case (ctrl_q.aluop)
            2'b01: bus.ALUControl = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  bus.ALUControl = (bus.op == OP_R && bus.funct7b5) ? 3'b001 : 3'b000;
                    3'b110:  bus.ALUControl = 3'b011;
                    3'b111:  bus.ALUControl = 3'b010;
                    default: bus.ALUControl = 3'b000;
                endcase
            end
            default: bus.ALUControl = 3'b000;
        endcase
    end

    assign bus.PCWrite   = ~reset & (ctrl_q.pcupdate | (ctrl_q.branch & bus.Zero));
    assign bus.IRWrite   = ~reset & ctrl_q.irwrite;
    assign bus.RegWrite  = ~reset & ctrl_q.regwrite;
    assign bus.MemWrite  = ~reset & ctrl_q.memwrite;
    assign bus.Illegal   = ~reset & ctrl_q.illegal;
    assign bus.AdrSrc    = ctrl_q.adrsrc;
    assign bus.ALUSrcA   = ctrl_q.alusrca;
    assign bus.ALUSrcB   = ctrl_q.alusrcb;
    assign bus.ResultSrc = ctrl_q.resultsrc;
    assign bus.ImmSrc    = ctrl_q.immsrc;
endmodule

// File: tb/tb_riscv_mc_controller.sv
// Scoreboard bench for riscv_mc_controller: stimulus queues hand-computed
// per-cycle control words, a monitor pops and compares them.
module tb_riscv_mc_controller;
    logic clk;
    logic reset;
    riscv_mc_controller_if bus();

    riscv_mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [16:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    event sample_ev;

    // {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ImmSrc,ALUControl,Illegal}
    function automatic logic [16:0] pk(input logic pcw, input logic irw, input logic rw,
                                       input logic mw, input logic adr,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] rs, input logic [1:0] imm,
                                       input logic [2:0] alc, input logic ill);
        return {pcw, irw, rw, mw, adr, sa, sb, rs, imm, alc, ill};
    endfunction

    localparam logic [16:0] E_FETCH   = pk(1,1,0,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0);
    localparam logic [16:0] E_RST     = pk(0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0);
    localparam logic [16:0] E_DEC     = pk(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b10, 3'b000, 0);
    localparam logic [16:0] E_MADR_LW = pk(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b000, 0);
    localparam logic [16:0] E_MADR_SW = pk(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b01, 3'b000, 0);
    localparam logic [16:0] E_MREAD   = pk(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0);
    localparam logic [16:0] E_MWRITE  = pk(0,0,0,1,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0);
    localparam logic [16:0] E_MWB     = pk(0,0,1,0,0, 2'b00,2'b00,2'b01,2'b00, 3'b000, 0);
    localparam logic [16:0] E_ALUWB   = pk(0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0);
    localparam logic [16:0] E_JAL     = pk(1,0,0,0,0, 2'b01,2'b10,2'b00,2'b11, 3'b000, 0);
    localparam logic [16:0] E_TRAP    = pk(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1);

    function automatic logic [16:0] e_execr(input logic [2:0] alc);
        return pk(0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, alc, 0);
    endfunction
    function automatic logic [16:0] e_execi(input logic [2:0] alc);
        return pk(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, alc, 0);
    endfunction
    function automatic logic [16:0] e_beq(input logic z);
        return pk(z,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b001, 0);
    endfunction

    initial begin : monitor
        exp_t        e;
        logic [16:0] got;
        forever begin
            @(negedge clk or sample_ev);
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
                       bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc,
                       bus.ALUControl, bus.Illegal};
                n_vec++;
                if (got !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %b expected %b (t=%0t)", e.name, got, e.exp, $time);
                end
            end
        end
    end

    task automatic push(input string name, input logic [16:0] e);
        exp_t x;
        x.name = name;
        x.exp  = e;
        q.push_back(x);
    endtask

    task automatic cyc(input string name, input logic [16:0] e);
        push(name, e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.Zero     = z;
    endtask

    // asserted mid-cycle; the check fires before any further clock edge
    task automatic async_reset(input string name);
        reset = 1'b1;
        #1;
        push(name, E_RST);
        -> sample_ev;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic r_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [16:0] e_exec);
        set_ir(op, f3, f7, 1'b1);
        cyc({name, "_fetch"}, E_FETCH);
        cyc({name, "_decode"}, E_DEC);
        cyc({name, "_exec"}, e_exec);
        cyc({name, "_aluwb"}, E_ALUWB);
    endtask

    task automatic illegal_instr(input string name, input logic [6:0] op,
                                 input logic [2:0] f3, input int hold);
        set_ir(op, f3, 1'b0, 1'b0);
        cyc({name, "_fetch"}, E_FETCH);
        cyc({name, "_decode"}, E_DEC);
        for (int i = 0; i < hold; i++) begin
            bus.Zero = i[0];
            cyc({name, "_trap"}, E_TRAP);
        end
        #2;
        async_reset({name, "_reset"});
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset = 1'b1;
        set_ir(7'b0, 3'b0, 1'b0, 1'b0);
        push("reset_hold", E_RST);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // lw: 5 cycles, Zero high must not leak into PCWrite
        set_ir(7'b0000011, 3'b010, 1'b0, 1'b1);
        cyc("lw_fetch", E_FETCH);
        cyc("lw_decode", E_DEC);
        cyc("lw_memadr", E_MADR_LW);
        cyc("lw_memread", E_MREAD);
        cyc("lw_memwb", E_MWB);

        set_ir(7'b0100011, 3'b010, 1'b0, 1'b1);
        cyc("sw_fetch", E_FETCH);
        cyc("sw_decode", E_DEC);
        cyc("sw_memadr", E_MADR_SW);
        cyc("sw_memwrite", E_MWRITE);

        r_instr("r_sub", 7'b0110011, 3'b000, 1'b1, e_execr(3'b001));
        r_instr("r_add", 7'b0110011, 3'b000, 1'b0, e_execr(3'b000));
        r_instr("r_or",  7'b0110011, 3'b110, 1'b0, e_execr(3'b011));
        r_instr("r_and", 7'b0110011, 3'b111, 1'b1, e_execr(3'b010));
        r_instr("i_addi_f7", 7'b0010011, 3'b000, 1'b1, e_execi(3'b000));
        r_instr("i_ori", 7'b0010011, 3'b110, 1'b0, e_execi(3'b011));

        set_ir(7'b1100011, 3'b000, 1'b0, 1'b1);
        cyc("beq_taken_fetch", E_FETCH);
        cyc("beq_taken_decode", E_DEC);
        cyc("beq_taken_beq", e_beq(1'b1));
        set_ir(7'b1100011, 3'b000, 1'b0, 1'b0);
        cyc("beq_not_fetch", E_FETCH);
        cyc("beq_not_decode", E_DEC);
        cyc("beq_not_beq", e_beq(1'b0));

        set_ir(7'b1101111, 3'b000, 1'b0, 1'b0);
        cyc("jal_fetch", E_FETCH);
        cyc("jal_decode", E_DEC);
        cyc("jal_jal", E_JAL);
        cyc("jal_aluwb", E_ALUWB);

        illegal_instr("ill_lui", 7'b0110111, 3'b000, 22);
        illegal_instr("ill_r_f3", 7'b0110011, 3'b010, 2);
        illegal_instr("ill_i_f3", 7'b0010011, 3'b001, 2);
        illegal_instr("ill_beq_f3", 7'b1100011, 3'b001, 2);

        // sw interrupted by reset during MEMWRITE
        set_ir(7'b0100011, 3'b010, 1'b0, 1'b0);
        cyc("swr_fetch", E_FETCH);
        cyc("swr_decode", E_DEC);
        cyc("swr_memadr", E_MADR_SW);
        push("swr_memwrite", E_MWRITE);
        #5;
        async_reset("swr_reset_in_memwrite");
        cyc("swr_post_fetch", E_FETCH);
        cyc("swr_post_decode", E_DEC);
        cyc("swr_post_memadr", E_MADR_SW);
        cyc("swr_post_memwrite", E_MWRITE);
        cyc("final_fetch", E_FETCH);

        #20;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/riscv_mc_controller.md
RISCV_MC_CONTROLLER -- requirements
Module: riscv_mc_controller

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have these input ports:
- `op`: input, 7 bits, instruction opcode from the IR.
- `funct3`: input, 3 bits, IR[14:12].
- `funct7b5`: input, 1 bit, IR[30].
- `Zero`: input, 1 bit, ALU result-equals-zero flag.
REQ-004 The block SHALL have these strobe output ports, each 1 bit:
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`: write strobes.
- `AdrSrc`: 0 = PC, 1 = result bus.
REQ-005 The block SHALL have these select output ports:
- `ALUSrcA`: 2 bits; 00 = PC, 01 = OldPC, 10 = rd1.
- `ALUSrcB`: 2 bits; 00 = rd2, 01 = ImmExt, 10 = constant 4.
- `ResultSrc`: 2 bits; 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ImmSrc`: 2 bits; 00 = I, 01 = S, 10 = B, 11 = J.
REQ-006 The block SHALL have the output port `ALUControl`, 3 bits, encoded 000 = ADD, 001 = SUB, 010 = AND, 011 = OR; bit 2 always 0.
REQ-007 The block SHALL have the output port `Illegal`, 1 bit, high while in TRAP.

Function
REQ-008 The block SHALL implement a Moore FSM with the states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL and TRAP.
REQ-009 The block SHALL decode these opcodes: lw = 0000011, sw = 0100011, R-type = 0110011, I-ALU = 0010011, beq = 1100011, jal = 1101111.
REQ-010 The block SHALL apply these transitions:
- FETCH -> DECODE, unconditionally.
- DECODE -> MEMADR on lw or sw.
- DECODE -> EXECR on R-type.
- DECODE -> EXECI on I-ALU.
- DECODE -> BEQ on beq.
- DECODE -> JAL on jal.
- DECODE -> TRAP on anything else.
REQ-011 The block SHALL apply these further transitions:
- MEMADR -> MEMREAD if op is lw, else MEMWRITE.
- MEMREAD -> MEMWB.
- EXECR and EXECI -> ALUWB.
- JAL -> ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
- TRAP -> TRAP until reset.
REQ-012 The block SHALL treat these as illegal and go to TRAP from DECODE:
- R-type or I-ALU with funct3 not in {000, 110, 111}.
- I-ALU with funct3 = 000 is legal regardless of funct7b5.
- beq with funct3 != 000.
REQ-013 The block SHALL drive `ALUControl` from an internal ALUOp (00 = add, 01 = sub, 10 = funct):
- funct with funct3 000 gives SUB if R-type and funct7b5 = 1, else ADD.
- funct with funct3 110 gives OR.
- funct with funct3 111 gives AND.
REQ-014 The block SHALL drive these per-state outputs; any output not listed is 0 or 00:
- FETCH: IRWrite = 1, PCUpdate = 1, ALUSrcA = 00, ALUSrcB = 10, ResultSrc = 10, ALUOp = 00.
- DECODE: ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00, ImmSrc = 10.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00, ImmSrc = 00 for lw or 01 for sw.
- MEMREAD: ResultSrc = 00, AdrSrc = 1.
- MEMWRITE: ResultSrc = 00, AdrSrc = 1, MemWrite = 1.
- MEMWB: ResultSrc = 01, RegWrite = 1.
REQ-015 The block SHALL drive these further per-state outputs:
- EXECR: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10, ImmSrc = 00.
- ALUWB: ResultSrc = 00, RegWrite = 1.
- BEQ: ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00, Branch = 1.
- JAL: ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCUpdate = 1, ImmSrc = 11.
- TRAP: all strobes 0, Illegal = 1.
REQ-016 The block SHALL compute `PCWrite` combinationally as PCUpdate OR (Branch AND Zero); `Zero` SHALL have no effect outside BEQ.
REQ-017 The block SHALL give these instruction latencies:
- lw: 5 cycles.
- sw, R-type, I-ALU, jal: 4 cycles.
- beq: 3 cycles.
REQ-018 The block SHALL sample `op`, `funct3` and `funct7b5` combinationally; the IR holds them stable from DECODE onward.

Reset
REQ-019 The block SHALL force the state to FETCH immediately and asynchronously when `reset` rises, including mid-instruction.
REQ-020 The block SHALL hold `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` and `Illegal` at 0 while `reset` is high; all other outputs take their FETCH values.
REQ-021 The block SHALL perform FETCH on the first rising edge of `clk` after `reset` falls.

Verification
REQ-022 The bench SHALL cover lw (op = 0000011):
- States FETCH, DECODE, MEMADR, MEMREAD, MEMWB, each for one cycle.
- RegWrite = 1 only in cycle 5, with ResultSrc = 01.
REQ-023 The bench SHALL cover R-type with funct3 = 000 and funct7b5 = 1:
- ALUControl = 001 in EXECR.
- The same instruction with funct7b5 = 0 gives 000.
- funct3 = 110 gives 011; funct3 = 111 gives 010.
REQ-024 The bench SHALL cover beq (op = 1100011, funct3 = 000):
- With Zero = 1: PCWrite = 1 in BEQ.
- With Zero = 0: PCWrite = 0 in BEQ.
- The next state is FETCH in both cases.
REQ-025 The bench SHALL cover illegal instructions:
- op = 0110111 gives TRAP with Illegal = 1 and all strobes 0 for 20 or more cycles.
- Asserting `reset` then returns the state to FETCH.
REQ-026 The bench SHALL cover reset during the MEMWRITE cycle of sw:
- MemWrite drops to 0 without waiting for `clk`.
- After release, the first cycle is FETCH with IRWrite = 1.
REQ-027 The bench SHALL cover I-ALU (op = 0010011) with funct3 = 000 and funct7b5 = 1:
- ALUControl = 000.
- ImmSrc = 00.
- Completes in 4 cycles.
